// File: rtl/ld_st_issue_queue_pkg.sv
// Shared packet types for the load/store issue queue and its neighbours.
package ld_st_issue_queue_pkg;

    localparam int unsigned PKT_BMASK_W = 4;
    localparam int unsigned PKT_ROB_W   = 5;
    localparam int unsigned PKT_PREG_W  = 6;

    typedef struct packed {
        logic                   valid;
        logic [PKT_BMASK_W-1:0] bmask;
        logic [2:0]             store_tag;
        logic                   store_tag_done;
        logic [PKT_ROB_W-1:0]   rob_idx;
        logic                   i_use_store;
        logic [1:0]             mem_size;
        logic [15:0]            imm;
    } ld_st_data_pkt_t;

    typedef struct packed {
        logic                           cdb_broadcast;
        logic [PKT_PREG_W-1:0]          pd;
        logic                           br_mispred;
        logic [$clog2(PKT_BMASK_W)-1:0] br_bit;
    } cdb_pkt_t;

endpackage

// File: rtl/ld_st_issue_queue.sv
// Unified load/store issue queue: buffers dispatched memory ops, wakes sources
// from the CDB, issues the oldest ready load and the oldest store (in order).
module ld_st_issue_queue
    import ld_st_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ROB_DEPTH = 32,
    parameter int unsigned PREG_W    = 6,
    parameter int unsigned BMASK_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         disp_valid,
    input  ld_st_data_pkt_t              disp_pkt,
    input  logic [PREG_W-1:0]            disp_rs1_preg,
    input  logic [PREG_W-1:0]            disp_rs2_preg,
    input  logic                         disp_rs1_rdy,
    input  logic                         disp_rs2_rdy,
    output logic                         full,
    input  logic [$clog2(ROB_DEPTH)-1:0] rob_head,
    input  cdb_pkt_t                     cdb_pkt2,
    input  logic                         ld_stall,
    input  logic                         st_stall,
    output logic                         ld_rs_done,
    output logic                         st_rs_done,
    output ld_st_data_pkt_t              rs_ld_pkt,
    output ld_st_data_pkt_t              rs_st_pkt,
    output logic [PREG_W-1:0]            ld_rs1_preg,
    output logic [PREG_W-1:0]            st_rs1_preg,
    output logic [PREG_W-1:0]            st_rs2_preg
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ROB_W = $clog2(ROB_DEPTH);

    logic            ent_valid_q    [DEPTH];
    logic            ent_valid_d    [DEPTH];
    ld_st_data_pkt_t ent_pkt_q      [DEPTH];
    ld_st_data_pkt_t ent_pkt_d      [DEPTH];
    logic [PREG_W-1:0] ent_rs1_preg_q [DEPTH];
    logic [PREG_W-1:0] ent_rs1_preg_d [DEPTH];
    logic [PREG_W-1:0] ent_rs2_preg_q [DEPTH];
    logic [PREG_W-1:0] ent_rs2_preg_d [DEPTH];
    logic            ent_rs1_rdy_q  [DEPTH];
    logic            ent_rs1_rdy_d  [DEPTH];
    logic            ent_rs2_rdy_q  [DEPTH];
    logic            ent_rs2_rdy_d  [DEPTH];

    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q;

    logic               cdb_wake;
    logic               br_kill;
    logic [BMASK_W-1:0] br_clr_mask;
    logic [DEPTH-1:0]   kill;
    logic [ROB_W-1:0]   age [DEPTH];

    logic             ld_found, st_found;
    logic [IDX_W-1:0] ld_idx, st_idx;
    logic [ROB_W-1:0] ld_age, st_age;
    logic             ld_fire, st_fire;

    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             disp_wr;
    logic             disp_rs1_cap, disp_rs2_cap;
    logic [CNT_W-1:0] kill_cnt;

    // Decode CDB into wakeup, kill and bmask-clear controls; compute per-entry age and kill.
    always_comb begin
        cdb_wake    = cdb_pkt2.cdb_broadcast && (cdb_pkt2.pd != '0);
        br_kill     = cdb_pkt2.cdb_broadcast && cdb_pkt2.br_mispred;
        br_clr_mask = (cdb_pkt2.cdb_broadcast && !cdb_pkt2.br_mispred) ?
                      (BMASK_W'(1) << cdb_pkt2.br_bit) : '0;
        kill        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age[i]  = ROB_W'(ent_pkt_q[i].rob_idx) - rob_head;
            kill[i] = ent_valid_q[i] && br_kill && ent_pkt_q[i].bmask[cdb_pkt2.br_bit];
        end
    end

    // Oldest ready load and oldest store (ready or not) by ROB-relative age.
    always_comb begin
        ld_found = 1'b0;
        ld_idx   = '0;
        ld_age   = '0;
        st_found = 1'b0;
        st_idx   = '0;
        st_age   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid_q[i] && !ent_pkt_q[i].i_use_store && ent_rs1_rdy_q[i] && !kill[i] &&
                (!ld_found || age[i] < ld_age)) begin
                ld_found = 1'b1;
                ld_idx   = IDX_W'(i);
                ld_age   = age[i];
            end
            if (ent_valid_q[i] && ent_pkt_q[i].i_use_store && (!st_found || age[i] < st_age)) begin
                st_found = 1'b1;
                st_idx   = IDX_W'(i);
                st_age   = age[i];
            end
        end
        ld_fire = ld_found && !ld_stall;
        // The oldest store blocks all younger stores until it is itself ready.
        st_fire = st_found && ent_rs1_rdy_q[st_idx] && ent_rs2_rdy_q[st_idx] &&
                  !kill[st_idx] && !st_stall;
    end

    // Issue outputs; the packet reflects this cycle's correct-predict bmask clear.
    always_comb begin
        rs_ld_pkt   = '0;
        ld_rs1_preg = '0;
        rs_st_pkt   = '0;
        st_rs1_preg = '0;
        st_rs2_preg = '0;
        if (ld_fire) begin
            rs_ld_pkt       = ent_pkt_q[ld_idx];
            rs_ld_pkt.bmask = ent_pkt_q[ld_idx].bmask & ~br_clr_mask;
            ld_rs1_preg     = ent_rs1_preg_q[ld_idx];
        end
        if (st_fire) begin
            rs_st_pkt       = ent_pkt_q[st_idx];
            rs_st_pkt.bmask = ent_pkt_q[st_idx].bmask & ~br_clr_mask;
            st_rs1_preg     = ent_rs1_preg_q[st_idx];
            st_rs2_preg     = ent_rs2_preg_q[st_idx];
        end
    end

    assign ld_rs_done = ld_fire;
    assign st_rs_done = st_fire;
    assign full       = full_q;

    // Next-state: wakeup, branch update, issue/kill frees, dispatch write and occupancy.
    always_comb begin
        ent_valid_d    = ent_valid_q;
        ent_pkt_d      = ent_pkt_q;
        ent_rs1_preg_d = ent_rs1_preg_q;
        ent_rs2_preg_d = ent_rs2_preg_q;
        ent_rs1_rdy_d  = ent_rs1_rdy_q;
        ent_rs2_rdy_d  = ent_rs2_rdy_q;
        free_found     = 1'b0;
        free_idx       = '0;
        kill_cnt       = '0;

        for (int i = 0; i < DEPTH; i++) begin
            if (!ent_valid_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (cdb_wake && ent_rs1_preg_q[i] == cdb_pkt2.pd) begin
                ent_rs1_rdy_d[i] = 1'b1;
            end
            if (cdb_wake && ent_rs2_preg_q[i] == cdb_pkt2.pd) begin
                ent_rs2_rdy_d[i] = 1'b1;
            end
            ent_pkt_d[i].bmask = ent_pkt_q[i].bmask & ~br_clr_mask;
            if (kill[i]) begin
                ent_valid_d[i] = 1'b0;
            end
            kill_cnt = kill_cnt + CNT_W'(kill[i]);
        end

        if (ld_fire) begin
            ent_valid_d[ld_idx] = 1'b0;
        end
        if (st_fire) begin
            ent_valid_d[st_idx] = 1'b0;
        end

        disp_rs1_cap = disp_rs1_rdy || (disp_rs1_preg == '0) ||
                       (cdb_wake && cdb_pkt2.pd == disp_rs1_preg);
        disp_rs2_cap = disp_rs2_rdy || (disp_rs2_preg == '0) ||
                       (cdb_wake && cdb_pkt2.pd == disp_rs2_preg);
        // An op dispatched under a branch being squashed this cycle is simply dropped.
        disp_wr = disp_valid && !full_q && free_found &&
                  !(br_kill && disp_pkt.bmask[cdb_pkt2.br_bit]);
        if (disp_wr) begin
            ent_valid_d[free_idx]     = 1'b1;
            ent_pkt_d[free_idx]       = disp_pkt;
            ent_pkt_d[free_idx].bmask = disp_pkt.bmask & ~br_clr_mask;
            ent_rs1_preg_d[free_idx]  = disp_rs1_preg;
            ent_rs2_preg_d[free_idx]  = disp_rs2_preg;
            ent_rs1_rdy_d[free_idx]   = disp_rs1_cap;
            ent_rs2_rdy_d[free_idx]   = disp_rs2_cap;
        end

        count_d = count_q + CNT_W'(disp_wr) - CNT_W'(ld_fire) - CNT_W'(st_fire) - kill_cnt;
    end

    // State registers; full is registered from the next occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_valid_q[i]    <= 1'b0;
                ent_pkt_q[i]      <= '0;
                ent_rs1_preg_q[i] <= '0;
                ent_rs2_preg_q[i] <= '0;
                ent_rs1_rdy_q[i]  <= 1'b0;
                ent_rs2_rdy_q[i]  <= 1'b0;
            end
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            ent_valid_q    <= ent_valid_d;
            ent_pkt_q      <= ent_pkt_d;
            ent_rs1_preg_q <= ent_rs1_preg_d;
            ent_rs2_preg_q <= ent_rs2_preg_d;
            ent_rs1_rdy_q  <= ent_rs1_rdy_d;
            ent_rs2_rdy_q  <= ent_rs2_rdy_d;
            count_q        <= count_d;
            full_q         <= (count_d == CNT_W'(DEPTH));
        end
    end

endmodule

// File: tb/tb_ld_st_issue_queue.sv
// Scoreboard bench for ld_st_issue_queue: stimulus pushes expected issues,
// a negedge monitor pops and compares each issue pulse.
module tb_ld_st_issue_queue;
    import ld_st_issue_queue_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            disp_valid;
    ld_st_data_pkt_t disp_pkt;
    logic [5:0]      disp_rs1_preg, disp_rs2_preg;
    logic            disp_rs1_rdy, disp_rs2_rdy;
    logic            full;
    logic [4:0]      rob_head;
    cdb_pkt_t        cdb_pkt2;
    logic            ld_stall, st_stall;
    logic            ld_rs_done, st_rs_done;
    ld_st_data_pkt_t rs_ld_pkt, rs_st_pkt;
    logic [5:0]      ld_rs1_preg, st_rs1_preg, st_rs2_preg;

    ld_st_issue_queue #(
        .DEPTH    (8),
        .ROB_DEPTH(32),
        .PREG_W   (6),
        .BMASK_W  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .disp_valid   (disp_valid),
        .disp_pkt     (disp_pkt),
        .disp_rs1_preg(disp_rs1_preg),
        .disp_rs2_preg(disp_rs2_preg),
        .disp_rs1_rdy (disp_rs1_rdy),
        .disp_rs2_rdy (disp_rs2_rdy),
        .full         (full),
        .rob_head     (rob_head),
        .cdb_pkt2     (cdb_pkt2),
        .ld_stall     (ld_stall),
        .st_stall     (st_stall),
        .ld_rs_done   (ld_rs_done),
        .st_rs_done   (st_rs_done),
        .rs_ld_pkt    (rs_ld_pkt),
        .rs_st_pkt    (rs_st_pkt),
        .ld_rs1_preg  (ld_rs1_preg),
        .st_rs1_preg  (st_rs1_preg),
        .st_rs2_preg  (st_rs2_preg)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [4:0] rob;
        logic [3:0] bm;
        logic [5:0] t1;
        logic [5:0] t2;
    } exp_t;

    exp_t ld_q[$];
    exp_t st_q[$];
    exp_t le, se;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every issue pulse must match the head of its scoreboard queue.
    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (ld_rs_done) begin
                tests++;
                if (ld_q.size() == 0) begin
                    fails++;
                    $display("FAIL ld_unexpected: cyc=%0d rob=%0d issued, required no load issue",
                             cyc, rs_ld_pkt.rob_idx);
                end else begin
                    le = ld_q.pop_front();
                    if (cyc != le.cyc || rs_ld_pkt.rob_idx !== le.rob || rs_ld_pkt.bmask !== le.bm ||
                        ld_rs1_preg !== le.t1 || rs_ld_pkt.i_use_store !== 1'b0 ||
                        rs_ld_pkt.valid !== 1'b1) begin
                        fails++;
                        $display("FAIL ld_issue: got cyc=%0d rob=%0d bm=%b t1=%0d, required cyc=%0d rob=%0d bm=%b t1=%0d",
                                 cyc, rs_ld_pkt.rob_idx, rs_ld_pkt.bmask, ld_rs1_preg,
                                 le.cyc, le.rob, le.bm, le.t1);
                    end
                end
            end else begin
                tests++;
                if (rs_ld_pkt !== '0 || ld_rs1_preg !== '0) begin
                    fails++;
                    $display("FAIL ld_idle_zero: pkt=%h tag=%0d, required 0", rs_ld_pkt, ld_rs1_preg);
                end
                if (ld_q.size() > 0 && ld_q[0].cyc <= cyc) begin
                    le = ld_q.pop_front();
                    fails++;
                    $display("FAIL ld_missing: no issue at cyc=%0d, required rob=%0d", cyc, le.rob);
                end
            end
            if (st_rs_done) begin
                tests++;
                if (st_q.size() == 0) begin
                    fails++;
                    $display("FAIL st_unexpected: cyc=%0d rob=%0d issued, required no store issue",
                             cyc, rs_st_pkt.rob_idx);
                end else begin
                    se = st_q.pop_front();
                    if (cyc != se.cyc || rs_st_pkt.rob_idx !== se.rob || rs_st_pkt.bmask !== se.bm ||
                        st_rs1_preg !== se.t1 || st_rs2_preg !== se.t2 ||
                        rs_st_pkt.i_use_store !== 1'b1) begin
                        fails++;
                        $display("FAIL st_issue: got cyc=%0d rob=%0d bm=%b t=%0d/%0d, required cyc=%0d rob=%0d bm=%b t=%0d/%0d",
                                 cyc, rs_st_pkt.rob_idx, rs_st_pkt.bmask, st_rs1_preg, st_rs2_preg,
                                 se.cyc, se.rob, se.bm, se.t1, se.t2);
                    end
                end
            end else begin
                tests++;
                if (rs_st_pkt !== '0 || st_rs1_preg !== '0 || st_rs2_preg !== '0) begin
                    fails++;
                    $display("FAIL st_idle_zero: pkt=%h tags=%0d/%0d, required 0",
                             rs_st_pkt, st_rs1_preg, st_rs2_preg);
                end
                if (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
                    se = st_q.pop_front();
                    fails++;
                    $display("FAIL st_missing: no issue at cyc=%0d, required rob=%0d", cyc, se.rob);
                end
            end
        end
    end

    task automatic push_ld(input int c, input int rob, input logic [3:0] bm, input int t1);
        exp_t e;
        e.cyc = c; e.rob = 5'(rob); e.bm = bm; e.t1 = 6'(t1); e.t2 = '0;
        ld_q.push_back(e);
    endtask

    task automatic push_st(input int c, input int rob, input logic [3:0] bm,
                           input int t1, input int t2);
        exp_t e;
        e.cyc = c; e.rob = 5'(rob); e.bm = bm; e.t1 = 6'(t1); e.t2 = 6'(t2);
        st_q.push_back(e);
    endtask

    task automatic disp_op(input bit is_st, input int rob, input logic [3:0] bm,
                           input int p1, input int p2, input bit r1, input bit r2);
        disp_valid           = 1'b1;
        disp_pkt             = '0;
        disp_pkt.valid       = 1'b1;
        disp_pkt.bmask       = bm;
        disp_pkt.rob_idx     = 5'(rob);
        disp_pkt.i_use_store = is_st;
        disp_pkt.imm         = 16'(rob * 4);
        disp_rs1_preg        = 6'(p1);
        disp_rs2_preg        = 6'(p2);
        disp_rs1_rdy         = r1;
        disp_rs2_rdy         = r2;
    endtask

    task automatic cdb(input int pd, input bit mis, input int bit_idx);
        cdb_pkt2.cdb_broadcast = 1'b1;
        cdb_pkt2.pd            = 6'(pd);
        cdb_pkt2.br_mispred    = mis;
        cdb_pkt2.br_bit        = 2'(bit_idx);
    endtask

    // Advance one clock; one-shot inputs drop back to idle after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        disp_valid    = 1'b0;
        disp_pkt      = '0;
        disp_rs1_preg = '0;
        disp_rs2_preg = '0;
        disp_rs1_rdy  = 1'b0;
        disp_rs2_rdy  = 1'b0;
        cdb_pkt2      = '0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rob_head = '0; ld_stall = 1'b0; st_stall = 1'b0;
        disp_valid = 1'b0; disp_pkt = '0; disp_rs1_preg = '0; disp_rs2_preg = '0;
        disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0; cdb_pkt2 = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_full", 64'(full), 0);
        check("rst_ld_done", 64'(ld_rs_done), 0);
        check("rst_st_done", 64'(st_rs_done), 0);
        check("rst_ld_pkt", 64'(rs_ld_pkt), 0);
        check("rst_st_pkt", 64'(rs_st_pkt), 0);
        check("rst_tags", 64'({ld_rs1_preg, st_rs1_preg, st_rs2_preg}), 0);
        mon_en = 1'b1;

        // Ready load issues the cycle after dispatch.
        disp_op(0, 3, 4'b0000, 1, 0, 1, 0);
        push_ld(cyc + 1, 3, 4'b0000, 1);
        tick(); check("t1_full_a", 64'(full), 0);
        tick(); check("t1_full_b", 64'(full), 0);
        tick();

        // Older unready store blocks the younger ready one until pd=9 arrives.
        disp_op(1, 5, 4'b0000, 2, 9, 1, 0); tick();
        disp_op(1, 6, 4'b0000, 3, 4, 1, 1); tick();
        tick(); tick(); tick();
        cdb(9, 0, 0);
        push_st(cyc + 1, 5, 4'b0000, 2, 9);
        push_st(cyc + 2, 6, 4'b0000, 3, 4);
        tick(); tick(); tick(); tick();

        // Loads issue by age relative to rob_head=2; a stall delays rob 6 one cycle.
        rob_head = 5'd2; ld_stall = 1'b1;
        disp_op(0, 7, 4'b0000, 10, 0, 1, 0); tick();
        disp_op(0, 4, 4'b0000, 11, 0, 1, 0); tick();
        disp_op(0, 6, 4'b0000, 12, 0, 1, 0); tick();
        ld_stall = 1'b0; push_ld(cyc, 4, 4'b0000, 11); tick();
        ld_stall = 1'b1; tick();
        ld_stall = 1'b0; push_ld(cyc, 6, 4'b0000, 12); tick();
        push_ld(cyc, 7, 4'b0000, 10); tick();
        tick();
        rob_head = '0;

        // Fill to 8, drop a further dispatch, drain one, refill, then squash all.
        for (int i = 0; i < 8; i++) begin
            disp_op(0, 16 + i, 4'b0100, 20 + i, 0, 0, 0);
            tick();
            check($sformatf("t4_fill_%0d", i), 64'(full), (i == 7) ? 1 : 0);
        end
        disp_op(0, 24, 4'b0000, 1, 0, 1, 0);
        tick(); check("t4_full_drop", 64'(full), 1);
        cdb(20, 0, 0);
        push_ld(cyc + 1, 16, 4'b0100, 20);
        tick(); check("t4_full_on_issue", 64'(full), 1);
        tick(); check("t4_full_after_issue", 64'(full), 0);
        disp_op(0, 25, 4'b0100, 28, 0, 0, 0);
        tick(); check("t4_refill", 64'(full), 1);
        cdb(0, 1, 2);
        tick(); check("t4_after_squash", 64'(full), 0);
        tick();

        // Mispredict on bit 1: only the 0001 entry survives and issues; the
        // same-cycle dispatch under bit 1 is dropped.
        ld_stall = 1'b1;
        disp_op(0, 1, 4'b0010, 5, 0, 1, 0); tick();
        disp_op(0, 2, 4'b0001, 6, 0, 1, 0); tick();
        disp_op(0, 3, 4'b0011, 7, 0, 1, 0); tick();
        ld_stall = 1'b0;
        cdb(0, 1, 1);
        disp_op(0, 4, 4'b0010, 8, 0, 1, 0);
        push_ld(cyc, 2, 4'b0001, 6);
        tick(); tick(); tick();

        // Correct predict on bit 0: issued bmasks 0000 (same cycle), 0010, 0010.
        ld_stall = 1'b1;
        disp_op(0, 11, 4'b0010, 5, 0, 1, 0); tick();
        disp_op(0, 10, 4'b0001, 6, 0, 1, 0); tick();
        disp_op(0, 12, 4'b0011, 7, 0, 1, 0); tick();
        ld_stall = 1'b0;
        cdb(0, 0, 0);
        push_ld(cyc, 10, 4'b0000, 6);
        push_ld(cyc + 1, 11, 4'b0010, 5);
        push_ld(cyc + 2, 12, 4'b0010, 7);
        tick(); tick(); tick(); tick();

        // One load and one store in the same cycle.
        ld_stall = 1'b1; st_stall = 1'b1;
        disp_op(1, 20, 4'b0000, 13, 14, 1, 1); tick();
        disp_op(0, 21, 4'b1000, 15, 0, 1, 0); tick();
        ld_stall = 1'b0; st_stall = 1'b0;
        push_ld(cyc, 21, 4'b1000, 15);
        push_st(cyc, 20, 4'b0000, 13, 14);
        tick(); tick(); tick();

        mon_en = 1'b0;
        tests++;
        if (ld_q.size() != 0 || st_q.size() != 0) begin
            fails++;
            $display("FAIL sb_drained: %0d loads %0d stores pending, required 0/0",
                     ld_q.size(), st_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ld_st_issue_queue.md
# ld_st_issue_queue

Unified load/store issue queue between dispatch/rename and the split load/store unit. It buffers dispatched memory ops, wakes their source operands from CDB broadcasts, and each cycle issues at most one load and one store. Loads go out oldest-ready first; stores go out strictly in program order. Each issue is a one-cycle `ld_rs_done`/`st_rs_done`-style pulse carrying a `ld_st_data_pkt_t` plus source preg tags for the PRF read.

## Interface
- `DEPTH`, 8: entries (power of two).
- `ROB_DEPTH`, 32: ROB entries; age is computed relative to ROB head.
- `PREG_W`, 6: physical register tag width.
- `BMASK_W`, 4: branch mask width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `disp_valid` in 1: dispatch request.
- `disp_pkt` in `ld_st_data_pkt_t`: op packet (`valid`, `bmask`, `store_tag`, `store_tag_done`, `rob_idx`, `i_use_store`, ...).
- `disp_rs1_preg`, `disp_rs2_preg` in `PREG_W`: source tags.
- `disp_rs1_rdy`, `disp_rs2_rdy` in 1: sources already ready at dispatch.
- `full` out 1: queue full; dispatch must hold.
- `rob_head` in `$clog2(ROB_DEPTH)`: current ROB head index.
- `cdb_pkt2` in `cdb_pkt_t`: `cdb_broadcast`, `pd` (`PREG_W`), `br_mispred`, `br_bit`.
- `ld_stall`, `st_stall` in 1: LSU `ld_unit_stall` / `st_unit_stall`.
- `ld_rs_done`, `st_rs_done` out 1: issue pulses.
- `rs_ld_pkt`, `rs_st_pkt` out `ld_st_data_pkt_t`: issued packets.
- `ld_rs1_preg`, `st_rs1_preg`, `st_rs2_preg` out `PREG_W`: PRF read tags.

## Operation
- Entry fields: `valid`, `pkt`, `rs1_preg`, `rs2_preg`, `rs1_rdy`, `rs2_rdy`. Occupancy counter is `$clog2(DEPTH)+1` bits.
- **Dispatch:**
  - When `disp_valid && !full`, write into the lowest-index free entry.
  - Capture `rs*_rdy = disp_rs*_rdy | (cdb_broadcast && pd == disp_rs*_preg && pd != 0)`.
  - Apply the same-cycle branch update to the written `bmask`/`valid`.
  - When `full` is high, dispatch is ignored (not an error).
- **Wakeup:** every valid entry whose `rs*_preg == cdb_pkt2.pd` (with `pd != 0` and `cdb_broadcast`) sets `rs*_rdy` at the clock edge. Preg 0 is always ready.
- **Age:** `age = rob_idx - rob_head` (mod `ROB_DEPTH`); smaller is older.
- **Load select:**
  - Candidates: valid, `!i_use_store`, `rs1_rdy`, not killed this cycle.
  - Pick the minimum age; ties cannot occur because ROB indices are unique.
  - `ld_rs_done = candidate_exists && !ld_stall`.
- **Store select:**
  - Consider only the oldest valid store.
  - It issues when `rs1_rdy && rs2_rdy && !st_stall` and it is not killed.
  - A younger ready store never bypasses an older unready store.
- **Issue:**
  - Outputs are combinational from registered entries; the issued entry is freed at the same edge.
  - When there is no issue, `rs_*_pkt = '0` and the tag outputs are 0.
  - The issued packet carries the same-cycle branch update: on a correct predict, `bmask[br_bit]` is cleared in the output.
- **Branch:**
  - `cdb_broadcast && br_mispred`: invalidate every entry with `bmask[br_bit]` set, and suppress its issue that cycle.
  - `cdb_broadcast && !br_mispred`: clear `bmask[br_bit]` in all entries.
- **Full:** `full = (count == DEPTH)`, registered. A same-cycle issue does not lower `full` until the next cycle.
- **Count:** next count = count + dispatch_accepted − ld_issue − st_issue − killed.

## Timing
- Reset values: all entries invalid, count 0, `full=0`, `ld_rs_done=st_rs_done=0`, packets and tags 0.
- Latency from dispatch (cycle N) to earliest issue is N+1.
- A CDB wakeup in cycle N allows issue in N+1.
- A stall in cycle N blocks issue in N only; the entry is retained.
- Max throughput: one load plus one store per cycle.
- Simultaneous dispatch and issue: both happen. Simultaneous dispatch and kill: an entry dispatched with a killed bit is never written.
- `rst` has priority over every other event.

## Test plan
- **Ready load:** reset, then dispatch a load with rob 3 and `disp_rs1_rdy=1` at cycle 1 → `ld_rs_done=1` at cycle 2 with `rs_ld_pkt.rob_idx=3`; `full=0` throughout.
- **Wakeup:** dispatch store rob 5 (rs2 preg 9 not ready), then store rob 6 (ready) → no `st_rs_done` until a CDB broadcast with `pd=9` at cycle T. Rob 5 issues at T+1, rob 6 at T+2.
- **Load age order:** loads rob 7, 4, 6 all ready with `rob_head=2` → issue order 4, 6, 7 over three cycles. With `ld_stall=1` on the second cycle, rob 6 issues one cycle late.
- **Full:** fill 8 entries → `full=1`; a further dispatch is dropped. One issue → `full=0` the next cycle, and count returns to 7.
- **Mispredict:** entries with bmask 0010, 0001, 0011 and a mispredict on `br_bit=1` → only the 0001 entry survives; no issue of killed entries that cycle.
- **Correct predict:** the same entries with a correct predict on `br_bit=0` → surviving bmasks are 0010, 0000, 0010.
